// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared widths and output-buffer depth for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
  localparam int AW_DEF = 9;
  localparam int DW_DEF = 64;
  localparam int OBUF_DEPTH = 2;
endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 2-entry output buffer; slot 0 is the head, capture is credit-guaranteed by the controller.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [1:0]    cnt_o
);
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [1:0] cnt_q, cnt_d, idx;
  logic pop;
  always_comb begin
    pop = out_ready_i && cnt_q != 2'd0;
    idx = cnt_q - {1'b0, pop};
    d0_d = (in_valid_i && idx == 2'd0) ? in_data_i : pop ? d1_q : d0_q;
    d1_d = (in_valid_i && idx == 2'd1) ? in_data_i : d1_q;
    cnt_d = cnt_q + {1'b0, in_valid_i} - {1'b0, pop};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
  end
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o = d0_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO controller around an external dual-port SRAM with a 2-entry prefetch buffer.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [DW-1:0] wr_data_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          sram_cenA_o,
  output logic [AW-1:0] sram_aA_o,
  output logic          sram_cenB_o,
  output logic [AW-1:0] sram_aB_o,
  output logic [DW-1:0] sram_d_o,
  output logic [DW-1:0] sram_bw_o,
  input  logic [DW-1:0] sram_q_i,
  output logic          sram_deepsleep_o,
  output logic          sram_powergate_o
);
  localparam int DEPTH = 2 ** AW;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic infl_q, infl_d;
  logic clr, full, pop, wr_fire, rd_issue;
  logic [1:0] buf_cnt;
  logic [2:0] occ;
  // A pop on this edge frees a buffer slot, so the refill read can issue in the same cycle.
  always_comb begin
    clr = rst_i || flush_i;
    full = cnt_q == (AW+1)'(DEPTH);
    pop = rd_valid_o && rd_ready_i;
    wr_fire = wr_valid_i && !full && !clr;
    occ = {1'b0, buf_cnt} + {2'b0, infl_q} - {2'b0, pop};
    rd_issue = !clr && cnt_q != '0 && occ < 3'(OBUF_DEPTH);
    wptr_d = flush_i ? '0 : wptr_q + AW'(wr_fire);
    rptr_d = flush_i ? '0 : rptr_q + AW'(rd_issue);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(wr_fire) - (AW+1)'(rd_issue);
    infl_d = rd_issue;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      infl_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      infl_q <= infl_d;
    end
  end
  sram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk_i      (clk_i),
    .rst_i      (clr),
    .in_valid_i (infl_q),
    .in_data_i  (sram_q_i),
    .out_valid_o(rd_valid_o),
    .out_ready_i(rd_ready_i),
    .out_data_o (rd_data_o),
    .cnt_o      (buf_cnt)
  );
  assign level_o = cnt_q + (AW+1)'(buf_cnt) + (AW+1)'(infl_q);
  assign full_o = full;
  assign wr_ready_o = !full;
  assign empty_o = level_o == '0;
  assign sram_cenA_o = !rd_issue;
  assign sram_aA_o = rptr_q;
  assign sram_cenB_o = !wr_fire;
  assign sram_aB_o = wptr_q;
  assign sram_d_o = wr_data_i;
  assign sram_bw_o = '1;
  assign sram_deepsleep_o = 1'b0;
  assign sram_powergate_o = 1'b0;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed self-checking bench with an inline 512x64 SRAM behaviour model.
module tb_sram_fifo_ctrl;
  localparam int AW = 9;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst, flush, wr_valid, wr_ready, rd_valid, rd_ready, full, empty;
  logic [DW-1:0] wr_data, rd_data, sram_d, sram_bw, sram_q;
  logic [AW:0] level;
  logic cen_a, cen_b, deepsleep, powergate;
  logic [AW-1:0] a_a, a_b;
  logic [DW-1:0] mem [0:511];
  logic [63:0] q[$];
  int n_cmp = 0, n_err = 0;
  int acc, exp_n, pushed, gaps;
  always #5 clk = ~clk;
  sram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .level_o(level), .full_o(full), .empty_o(empty),
    .sram_cenA_o(cen_a), .sram_aA_o(a_a),
    .sram_cenB_o(cen_b), .sram_aB_o(a_b), .sram_d_o(sram_d), .sram_bw_o(sram_bw),
    .sram_q_i(sram_q), .sram_deepsleep_o(deepsleep), .sram_powergate_o(powergate)
  );
  always @(posedge clk) begin
    if (!cen_b) mem[a_b] <= sram_d;
    if (!cen_a) sram_q <= mem[a_a];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_cenA"}, cen_a, 1);
    chk({tag, "_cenB"}, cen_b, 1);
  endtask
  initial begin
    rst = 1; flush = 0; wr_valid = 0; wr_data = '0; rd_ready = 0;
    cyc(); cyc();
    rst = 0; #1;
    chk_reset("reset");
    chk("deepsleep", deepsleep, 0);
    chk("powergate", powergate, 0);
    // single word latency
    wr_valid = 1; wr_data = {16{4'h1}}; rd_ready = 1; #1;
    chk("push_cenB", cen_b, 0);
    chk("push_aB", a_b, 0);
    chk("push_d", sram_d, {16{4'h1}});
    chk("push_bw", sram_bw, '1);
    cyc(); wr_valid = 0; #1;
    chk("lat_n0_valid", rd_valid, 0);
    chk("lat_n0_level", level, 1);
    chk("lat_n0_cenA", cen_a, 0);
    chk("lat_n0_aA", a_a, 0);
    cyc();
    chk("lat_n1_valid", rd_valid, 0);
    chk("lat_n1_level", level, 1);
    cyc();
    chk("lat_n2_valid", rd_valid, 1);
    chk("lat_n2_data", rd_data, {16{4'h1}});
    cyc();
    chk("lat_pop_valid", rd_valid, 0);
    chk("lat_pop_level", level, 0);
    chk("lat_pop_empty", empty, 1);
    chk("lat_wptr", a_b, 1);
    chk("lat_rptr", a_a, 1);
    cyc();
    chk("idle_ready_level", level, 0);
    chk("idle_ready_valid", rd_valid, 0);
    // fill to full without popping
    rd_ready = 0; acc = 0;
    for (int i = 0; i < 514; i++) begin
      wr_valid = 1; wr_data = 64'(i); #1;
      if (wr_ready) acc++;
      cyc();
    end
    wr_valid = 0; #1;
    chk("fill_accepted", acc, 514);
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_level", level, 514);
    chk("fill_rd_valid", rd_valid, 1);
    chk("fill_head", rd_data, 0);
    wr_valid = 1; wr_data = 64'hDEAD; #1;
    chk("full_push_cenB", cen_b, 1);
    cyc(); wr_valid = 0;
    chk("full_push_level", level, 514);
    chk("full_push_full", full, 1);
    rd_ready = 1; exp_n = 0;
    for (int c = 0; c < 600 && exp_n < 514; c++) begin
      if (rd_valid) begin chk("fill_order", rd_data, 64'(exp_n)); exp_n++; end
      cyc();
    end
    chk("fill_drained", exp_n, 514);
    chk("fill_end_level", level, 0);
    chk("fill_end_empty", empty, 1);
    // sustained streaming
    pushed = 0; exp_n = 0; gaps = 0;
    for (int c = 0; c < 2100 && exp_n < 2000; c++) begin
      wr_valid = pushed < 2000; wr_data = 64'h1_0000 + 64'(pushed); #1;
      if (wr_valid && wr_ready) pushed++;
      if (rd_valid) begin chk("stream_order", rd_data, 64'h1_0000 + 64'(exp_n)); exp_n++; end
      else if (exp_n > 0) gaps++;
      cyc();
    end
    wr_valid = 0; #1;
    chk("stream_count", exp_n, 2000);
    chk("stream_gaps", gaps, 0);
    chk("stream_level", level, 0);
    // random traffic against a queue model
    for (int c = 0; c < 800; c++) begin
      wr_valid = 1'($urandom_range(0, 1)); rd_ready = 1'($urandom_range(0, 1));
      wr_data = {$urandom, $urandom}; #1;
      chk("rand_level", level, q.size());
      if (rd_valid && rd_ready) chk("rand_data", rd_data, q.size() > 0 ? q.pop_front() : 'x);
      if (wr_valid && wr_ready) q.push_back(wr_data);
      cyc();
    end
    wr_valid = 0; rd_ready = 1;
    for (int c = 0; c < 1000 && q.size() > 0; c++) begin
      if (rd_valid) chk("rand_drain_data", rd_data, q.pop_front());
      cyc();
    end
    chk("rand_drain_level", level, 0);
    chk("rand_drain_valid", rd_valid, 0);
    // flush with a read in flight
    rd_ready = 0;
    for (int i = 0; i < 11; i++) begin
      wr_valid = 1; wr_data = 64'h100 + 64'(i); cyc();
    end
    wr_valid = 0; cyc(); cyc();
    rd_ready = 1; cyc(); rd_ready = 0; #1;
    chk("pre_flush_level", level, 10);
    flush = 1; wr_valid = 1; wr_data = 64'h55; #1;
    chk("flush_push_dropped", cen_b, 1);
    cyc(); flush = 0; wr_valid = 0; #1;
    chk("flush_level", level, 0);
    chk("flush_rd_valid", rd_valid, 0);
    chk("flush_empty", empty, 1);
    chk("flush_wptr", a_b, 0);
    chk("flush_rptr", a_a, 0);
    cyc();
    chk("flush_stale_capture", rd_valid, 0);
    wr_valid = 1; wr_data = 64'hAB; rd_ready = 1; cyc(); wr_valid = 0;
    for (int c = 0; c < 10 && !rd_valid; c++) cyc();
    chk("post_flush_valid", rd_valid, 1);
    chk("post_flush_data", rd_data, 64'hAB);
    cyc();
    chk("post_flush_level", level, 0);
    // reset mid-stream
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1; wr_data = 64'h900 + 64'(i); cyc();
    end
    rst = 1; cyc(); rst = 0; wr_valid = 0; #1;
    chk_reset("midrst");
    wr_valid = 1; wr_data = 64'h77; cyc(); wr_valid = 0; cyc(); cyc();
    chk("post_rst_valid", rd_valid, 1);
    chk("post_rst_data", rd_data, 64'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
